reg_bank_sequencer: RTL and testbench

REG_BANK_SEQUENCER -- requirements
Module: reg_bank_sequencer

---
 rtl/reg_bank_pkg.sv | 53 +++++
 rtl/reg_bank_sequencer.sv | 163 ++++++++++++++++
 tb/tb_reg_bank_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_pkg.sv
// Shared encodings for the register-bank sequencer: ctrl field layout,
// load-select codes, request op codes and FSM states.
package reg_bank_pkg;

  localparam int CTRL_ESC_REG1  = 0;
  localparam int CTRL_ESC_REG2  = 1;
  localparam int CTRL_PILHA1    = 2;
  localparam int CTRL_PILHA2    = 3;
  localparam int CTRL_EMPDESEMP = 4;
  localparam int CTRL_SEL_LSB   = 5;

  typedef enum logic [2:0] {
    SEL_NONE   = 3'd0,
    SEL_REG    = 3'd1,
    SEL_HI     = 3'd2,
    SEL_LO     = 3'd3,
    SEL_TIME   = 3'd4,
    SEL_PTIME  = 3'd5,
    SEL_MULDIV = 3'd6,
    SEL_RF     = 3'd7
  } load_sel_e;

  typedef enum logic [2:0] {
    OP_READ      = 3'd0,
    OP_WRITE     = 3'd1,
    OP_MULDIV    = 3'd2,
    OP_PUSH      = 3'd3,
    OP_POP       = 3'd4,
    OP_DELAY     = 3'd5,
    OP_READ_TIME = 3'd6,
    OP_CMP       = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    IDLE, ISSUE, CAPTURE, DLY_LOAD, DLY_PULSE, DLY_SETTLE, DLY_WAIT, DONE
  } state_e;

  localparam logic [4:0] FLAG_NONE      = 5'd0;
  localparam logic [4:0] FLAG_ESC1      = 5'(1 << CTRL_ESC_REG1);
  localparam logic [4:0] FLAG_ESC2      = 5'(1 << CTRL_ESC_REG2);
  localparam logic [4:0] FLAG_PILHA1    = 5'(1 << CTRL_PILHA1);
  localparam logic [4:0] FLAG_PILHA2    = 5'(1 << CTRL_PILHA2);
  localparam logic [4:0] FLAG_EMPDESEMP = 5'(1 << CTRL_EMPDESEMP);

  function automatic logic [7:0] make_ctrl(input load_sel_e sel, input logic [4:0] flags);
    logic [7:0] c;
    c = 8'd0;
    c[CTRL_SEL_LSB +: 3] = sel;
    c[4:0] = flags;
    return c;
  endfunction

endpackage

// File: rtl/reg_bank_sequencer.sv
// Sequences register-bank operations (read, write, stack, mul/div load, compare,
// timed delay) from a valid/ready request and returns a one-cycle completion.
module reg_bank_sequencer
  import reg_bank_pkg::*;
#(
  parameter logic [31:0] WAIT_MAX = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_wdata_hi,
  input  logic        abort,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata0,
  output logic [31:0] rsp_rdata1,
  output logic [4:0]  RL0,
  output logic [4:0]  RL1,
  output logic [4:0]  RE0,
  output logic [31:0] esc0,
  output logic [31:0] esc1,
  output logic [7:0]  ctrl,
  output logic        delay,
  input  logic [31:0] D0,
  input  logic [31:0] D1,
  input  logic        DL
);

  state_e      state, next_state;
  op_e         op_q;
  logic [4:0]  rs_q, rt_q, rd_q;
  logic [31:0] wdata_q, wdata_hi_q;
  logic [31:0] wait_cnt, wait_inc;
  logic        err_q;
  logic        accept;

  assign accept   = req_valid && req_ready;
  assign wait_inc = (wait_cnt >= WAIT_MAX) ? WAIT_MAX : wait_cnt + 32'd1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:       if (accept) next_state = (op_e'(req_op) == OP_DELAY) ? DLY_LOAD : ISSUE;
      ISSUE:      next_state = (op_q == OP_READ || op_q == OP_READ_TIME) ? CAPTURE : DONE;
      CAPTURE:    next_state = DONE;
      DLY_LOAD:   next_state = DLY_PULSE;
      DLY_PULSE:  next_state = DLY_SETTLE;
      DLY_SETTLE: next_state = DLY_WAIT;
      DLY_WAIT:   if (!DL || abort) next_state = DONE;
      DONE:       next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    req_ready = (state == IDLE) && !reset;
    rsp_valid = (state == DONE) && !reset;
    rsp_err   = (state == DONE) && !reset && err_q;
    ctrl      = 8'd0;
    delay     = 1'b0;
    esc0      = 32'd0;
    esc1      = 32'd0;
    RL0       = 5'd0;
    RL1       = 5'd0;
    RE0       = 5'd0;
    unique case (state)
      ISSUE: begin
        unique case (op_q)
          OP_READ: begin
            ctrl = make_ctrl(SEL_REG, FLAG_NONE);
            RL0  = rs_q;
            RL1  = rt_q;
          end
          OP_WRITE: begin
            ctrl = make_ctrl(SEL_NONE, FLAG_ESC1);
            RE0  = rd_q;
            esc0 = wdata_q;
          end
          OP_MULDIV: begin
            ctrl = make_ctrl(SEL_MULDIV, FLAG_NONE);
            esc0 = wdata_q;
            esc1 = wdata_hi_q;
          end
          OP_PUSH:      ctrl = make_ctrl(SEL_NONE, FLAG_PILHA2);
          OP_POP:       ctrl = make_ctrl(SEL_NONE, FLAG_PILHA2 | FLAG_EMPDESEMP);
          OP_READ_TIME: ctrl = make_ctrl(SEL_TIME, FLAG_NONE);
          OP_CMP:       ctrl = make_ctrl(SEL_NONE, FLAG_ESC1 | FLAG_ESC2);
          default:      ctrl = 8'd0;
        endcase
      end
      DLY_LOAD: begin
        // Loads the delay period into the bank's PTIME register.
        ctrl = make_ctrl(SEL_MULDIV, FLAG_ESC1 | FLAG_ESC2);
        esc0 = wdata_q;
      end
      DLY_PULSE: delay = 1'b1;
      default: ;
    endcase
  end

  // NOTE: the request payload only drives outputs while ISSUE/DLY_LOAD are
  // active, so it needs no reset; only control and result state is cleared.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q       <= op_e'(req_op);
      rs_q       <= req_rs;
      rt_q       <= req_rt;
      rd_q       <= req_rd;
      wdata_q    <= req_wdata;
      wdata_hi_q <= req_wdata_hi;
    end
  end

  // Results load only on the transition into DONE and hold until the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt   <= 32'd0;
      rsp_rdata0 <= 32'd0;
      rsp_rdata1 <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      if (accept)                 wait_cnt <= 32'd0;
      else if (state == DLY_WAIT) wait_cnt <= wait_inc;

      if (next_state == DONE) begin
        unique case (state)
          CAPTURE: begin
            rsp_rdata0 <= D0;
            rsp_rdata1 <= (op_q == OP_READ) ? D1 : 32'd0;
            err_q      <= 1'b0;
          end
          DLY_WAIT: begin
            // A low DL means normal completion, even if abort arrives together.
            rsp_rdata0 <= wait_inc;
            rsp_rdata1 <= 32'd0;
            err_q      <= DL;
          end
          default: begin
            rsp_rdata0 <= 32'd0;
            rsp_rdata1 <= 32'd0;
            err_q      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Self-checking bench: behavioural register-bank model plus a response scoreboard.
module tb_reg_bank_sequencer;
  import reg_bank_pkg::*;

  localparam logic [31:0] WAIT_MAX = 32'd25;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, abort, rsp_valid, rsp_err, delay, DL;
  logic [2:0]  req_op;
  logic [4:0]  req_rs, req_rt, req_rd, RL0, RL1, RE0;
  logic [31:0] req_wdata, req_wdata_hi, rsp_rdata0, rsp_rdata1, esc0, esc1, D0, D1;
  logic [7:0]  ctrl;

  always #5 clk = ~clk;

  reg_bank_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_wdata(req_wdata), .req_wdata_hi(req_wdata_hi), .abort(abort),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata0(rsp_rdata0), .rsp_rdata1(rsp_rdata1),
    .RL0(RL0), .RL1(RL1), .RE0(RE0), .esc0(esc0), .esc1(esc1), .ctrl(ctrl), .delay(delay),
    .D0(D0), .D1(D1), .DL(DL)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- register-bank model ----------------
  logic        bank_rst, time_run, force_dl, dl_val, pending, cm;
  logic [31:0] regs [32];
  logic [31:0] sp, hi, lo, ptime, time_cnt, target;
  int          prescale;

  assign DL = force_dl ? dl_val : (pending && (time_cnt < target));

  always @(posedge clk) begin
    if (bank_rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      D0 <= '0; D1 <= '0; sp <= '0; hi <= '0; lo <= '0; ptime <= '0;
      time_cnt <= 32'h77; prescale <= 0; pending <= 1'b0; target <= '0; cm <= 1'b0;
    end else begin
      if (time_run) begin
        if (prescale == 9) begin prescale <= 0; time_cnt <= time_cnt + 1; end
        else prescale <= prescale + 1;
      end
      case (ctrl)
        8'h20: begin D0 <= regs[RL0]; D1 <= regs[RL1]; end
        8'h80: D0 <= time_cnt;
        8'h01: if (RE0 != 5'd0) regs[RE0] <= esc0;
        8'hC0: begin lo <= esc0; hi <= esc1; end
        8'hC3: ptime <= esc0;
        8'h08: sp <= sp - 32'd4;
        8'h18: sp <= sp + 32'd4;
        8'h03: cm <= 1'b1;
        default: ;
      endcase
      if (delay) begin pending <= 1'b1; target <= time_cnt + ptime; end
      else if (pending && time_cnt >= target) pending <= 1'b0;
    end
  end

  // ---------------- scoreboard and monitor ----------------
  typedef struct {
    string       tag;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] d1;
    logic        err;
    int          lat;
  } exp_t;

  function automatic exp_t mk(input string tag, input logic [31:0] lo, input logic [31:0] hi,
                              input logic [31:0] d1, input logic err, input int lat);
    exp_t e;
    e.tag = tag; e.lo = lo; e.hi = hi; e.d1 = d1; e.err = err; e.lat = lat;
    return e;
  endfunction

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          last_acc = 0;
  int          ctrl_cycles = 0, delay_cycles = 0, rsp_count = 0;
  int          base_ctrl = 0, base_delay = 0;
  logic [7:0]  ctrl_last = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ctrl != 8'd0) begin ctrl_cycles++; ctrl_last = ctrl; end
    if (delay) delay_cycles++;
    if (rsp_valid) begin
      rsp_count++;
      if (sb.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 0);
      else begin
        mon_e = sb.pop_front();
        if (mon_e.lo == mon_e.hi) check({mon_e.tag, "_d0"}, rsp_rdata0, mon_e.lo);
        else check({mon_e.tag, "_d0_range"},
                   32'((rsp_rdata0 >= mon_e.lo) && (rsp_rdata0 <= mon_e.hi)), 1);
        check({mon_e.tag, "_d1"}, rsp_rdata1, mon_e.d1);
        check({mon_e.tag, "_err"}, 32'(rsp_err), 32'(mon_e.err));
        if (mon_e.lat > 0) check({mon_e.tag, "_lat"}, 32'(cyc + 1 - last_acc), 32'(mon_e.lat));
        check({mon_e.tag, "_quiet"}, 32'(|{ctrl, delay, RL0, RL1, RE0, esc0, esc1}), 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input op_e op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [31:0] w, input logic [31:0] whi, input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) begin
      check({e.tag, "_ready_timeout"}, 32'(req_ready), 1);
      return;
    end
    req_valid = 1'b1; req_op = op; req_rs = rs; req_rt = rt; req_rd = rd;
    req_wdata = w; req_wdata_hi = whi;
    sb.push_back(e);
    @(posedge clk); #1;
    last_acc = cyc; base_ctrl = ctrl_cycles; base_delay = delay_cycles;
    req_valid = 1'b0;
    @(negedge clk);
    check({e.tag, "_ready_low"}, 32'(req_ready), 0);
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      check("rsp_timeout", 32'(sb.size()), 0);
      sb.delete();
    end
  endtask

  task automatic do_op(input op_e op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] w, input logic [31:0] whi, input exp_t e, input logic [7:0] exp_ctrl);
    send(op, rs, rt, rd, w, whi, e);
    wait_rsp();
    check({e.tag, "_ctrl"}, 32'(ctrl_last), 32'(exp_ctrl));
    check({e.tag, "_ctrl_cycles"}, 32'(ctrl_cycles - base_ctrl), 1);
  endtask

  task automatic wait_pulse(input string tag);
    int n;
    n = 0;
    while (!delay && n < 50) begin @(negedge clk); n++; end
    if (!delay) check({tag, "_pulse_timeout"}, 32'(delay), 1);
  endtask

  // Abort (optionally with DL dropping together) during wait cycle at_cycle.
  task automatic delay_abort(input int at_cycle, input logic dl_drop, input exp_t e);
    force_dl = 1'b1; dl_val = 1'b1;
    send(OP_DELAY, 5'd0, 5'd0, 5'd0, 32'd3, 32'd0, e);
    wait_pulse(e.tag);
    @(posedge clk);
    repeat (at_cycle) @(posedge clk);
    #1;
    abort = 1'b1;
    if (dl_drop) dl_val = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0; dl_val = 1'b1;
    wait_rsp();
    force_dl = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_rsp;
    reset = 1'b1; bank_rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rs = '0; req_rt = '0;
    req_rd = '0; req_wdata = '0; req_wdata_hi = '0; abort = 1'b0;
    time_run = 1'b0; force_dl = 1'b0; dl_val = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 0);
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_ctrl", 32'(ctrl), 0);
    check("rst_rdata0", rsp_rdata0, 0);
    @(negedge clk); reset = 1'b0; bank_rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(req_ready), 1);

    do_op(OP_WRITE, 5'd0, 5'd0, 5'd3, 32'h1234, 32'd0, mk("wr3", 0, 0, 0, 0, 2), 8'h01);
    do_op(OP_WRITE, 5'd0, 5'd0, 5'd4, 32'hBEEF, 32'd0, mk("wr4", 0, 0, 0, 0, 2), 8'h01);
    do_op(OP_READ, 5'd3, 5'd4, 5'd0, 32'd0, 32'd0, mk("rd34", 32'h1234, 32'h1234, 32'hBEEF, 0, 3), 8'h20);
    do_op(OP_WRITE, 5'd0, 5'd0, 5'd5, 32'hA5A5, 32'd0, mk("wr5", 0, 0, 0, 0, 2), 8'h01);
    do_op(OP_READ, 5'd5, 5'd0, 5'd0, 32'd0, 32'd0, mk("rd5", 32'hA5A5, 32'hA5A5, 0, 0, 3), 8'h20);
    do_op(OP_WRITE, 5'd0, 5'd0, 5'd0, 32'hDEAD, 32'd0, mk("wr0", 0, 0, 0, 0, 2), 8'h01);
    do_op(OP_READ, 5'd0, 5'd3, 5'd0, 32'd0, 32'd0, mk("rd0", 0, 0, 32'h1234, 0, 3), 8'h20);

    do_op(OP_MULDIV, 5'd0, 5'd0, 5'd0, 32'h1111, 32'h2222, mk("muldiv", 0, 0, 0, 0, 2), 8'hC0);
    check("muldiv_lo", lo, 32'h1111);
    check("muldiv_hi", hi, 32'h2222);

    send(OP_PUSH, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, mk("push1", 0, 0, 0, 0, 2));
    send(OP_PUSH, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, mk("push2", 0, 0, 0, 0, 2));
    @(negedge clk);
    check("sp_after_push", sp, 32'hFFFF_FFF8);
    send(OP_POP, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, mk("pop", 0, 0, 0, 0, 2));
    wait_rsp();
    check("pop_ctrl", 32'(ctrl_last), 32'h18);
    check("sp_after_pop", sp, 32'hFFFF_FFFC);

    do_op(OP_CMP, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, mk("cmp", 0, 0, 0, 0, 2), 8'h03);
    check("cmp_latched", 32'(cm), 1);

    do_op(OP_READ, 5'd3, 5'd4, 5'd0, 32'd0, 32'd0, mk("rd34b", 32'h1234, 32'h1234, 32'hBEEF, 0, 3), 8'h20);
    abort = 1'b1;
    do_op(OP_READ_TIME, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, mk("rtime", 32'h77, 32'h77, 0, 0, 3), 8'h80);
    abort = 1'b0;

    time_run = 1'b1;
    send(OP_DELAY, 5'd0, 5'd0, 5'd0, 32'd2, 32'd0, mk("dly2", 32'd10, 32'd20, 0, 0, 0));
    wait_rsp();
    time_run = 1'b0;
    check("dly2_ctrl", 32'(ctrl_last), 32'hC3);
    check("dly2_ctrl_cycles", 32'(ctrl_cycles - base_ctrl), 1);
    check("dly2_pulse_cycles", 32'(delay_cycles - base_delay), 1);

    delay_abort(7, 1'b0, mk("abort7", 32'd7, 32'd7, 0, 1, 0));
    delay_abort(3, 1'b1, mk("abort_dl_tie", 32'd3, 32'd3, 0, 0, 0));
    delay_abort(40, 1'b0, mk("abort_sat", WAIT_MAX, WAIT_MAX, 0, 1, 0));

    force_dl = 1'b1; dl_val = 1'b1;
    send(OP_DELAY, 5'd0, 5'd0, 5'd0, 32'd5, 32'd0, mk("rst_dly", 0, 0, 0, 0, 0));
    wait_pulse("rst_dly");
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    base_rsp = rsp_count;
    @(posedge clk); #1;
    check("mid_rst_ready", 32'(req_ready), 0);
    check("mid_rst_valid", 32'(rsp_valid), 0);
    check("mid_rst_ctrl", 32'(ctrl), 0);
    check("mid_rst_rdata0", rsp_rdata0, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_ready_after", 32'(req_ready), 1);
    repeat (10) @(negedge clk);
    check("mid_rst_no_rsp", 32'(rsp_count - base_rsp), 0);
    force_dl = 1'b0;

    do_op(OP_READ, 5'd5, 5'd0, 5'd0, 32'd0, 32'd0, mk("rd5_after_rst", 32'hA5A5, 32'hA5A5, 0, 0, 3), 8'h20);
    delay_abort(2, 1'b0, mk("abort2_after_rst", 32'd2, 32'd2, 0, 1, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
